alu_md_unit: RTL

ALU_MD_UNIT -- requirements
Module: alu_md_unit

---
 rtl/alu_md_unit.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/alu_md_unit.sv
// Combinational ALU with an iterative multiply/divide unit beside it.
// Multiply is shift-add and divide is restoring, one bit per cycle, on magnitudes with the signs fixed at the end.
module alu_md_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       aluop,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             start,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int SHW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t               state, state_nxt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opd;
   logic [SHW-1:0]       cnt;
   logic                 neg_q, neg_r;

   logic                 md_op, sgn_op, accept, last;
   logic [SHW-1:0]       shamt;
   logic [WIDTH:0]       mul_sum;
   logic [2*WIDTH-1:0]   mul_nxt, mul_fix;
   logic [WIDTH:0]       div_sh, div_diff;
   logic                 qbit;
   logic [WIDTH-1:0]     rem_nxt;
   logic [2*WIDTH-1:0]   div_nxt;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic sgn);
      return (sgn && v[WIDTH-1]) ? -v : v;
   endfunction

   assign md_op  = (funct[5:2] == 4'b0110);
   assign sgn_op = ~funct[0];
   assign accept = start && (state == IDLE) && (aluop == 2'b10) && md_op;
   assign last   = (cnt == SHW'(WIDTH-1));
   assign shamt  = b[SHW-1:0];

   // acc holds {partial product, remaining multiplier bits}; shifting right retires one multiplier bit
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opd} : '0);
   assign mul_nxt = {mul_sum, acc[WIDTH-1:1]};
   assign mul_fix = neg_q ? -mul_nxt : mul_nxt;

   // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
   assign div_sh   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_diff = div_sh - {1'b0, opd};
   assign qbit     = ~div_diff[WIDTH];
   assign rem_nxt  = qbit ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
   assign div_nxt  = {rem_nxt, acc[WIDTH-2:0], qbit};

   always_comb begin
      result = '0;
      case (aluop)
         2'b00: result = a + b;
         2'b01: result = a - b;
         2'b11: result = a | b;
         default: begin
            case (funct)
               6'b100000, 6'b100001: result = a + b;
               6'b100010, 6'b100011: result = a - b;
               6'b100100: result = a & b;
               6'b100101: result = a | b;
               6'b100110: result = a ^ b;
               6'b100111: result = ~(a | b);
               6'b101010: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
               6'b101011: result = {{(WIDTH-1){1'b0}}, (a < b)};
               6'b000000: result = a << shamt;
               6'b000010: result = a >> shamt;
               6'b000011: result = $signed(a) >>> shamt;
               6'b010000: result = hi;
               6'b010010: result = lo;
               default:   result = '0;
            endcase
         end
      endcase
   end

   assign zero = (result == '0);

   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      case (state)
         IDLE: begin
            if (accept) state_nxt = funct[1] ? DIV : MUL;
         end
         MUL: begin
            busy = 1'b1;
            if (last) state_nxt = DONE;
         end
         DIV: begin
            busy = 1'b1;
            if (opd == '0 || last) state_nxt = DONE;
         end
         default: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc   <= '0;
         opd   <= '0;
         cnt   <= '0;
         neg_q <= 1'b0;
         neg_r <= 1'b0;
         hi    <= '0;
         lo    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  acc   <= {{WIDTH{1'b0}}, mag(a, sgn_op)};
                  opd   <= mag(b, sgn_op);
                  cnt   <= '0;
                  neg_q <= sgn_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r <= sgn_op & a[WIDTH-1];
               end
            end
            MUL: begin
               acc <= mul_nxt;
               cnt <= cnt + 1'b1;
               if (last) begin
                  hi <= mul_fix[2*WIDTH-1:WIDTH];
                  lo <= mul_fix[WIDTH-1:0];
               end
            end
            DIV: begin
               // divide by zero: dividend is still untouched in the low half, rebuild its sign
               if (opd == '0) begin
                  hi <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                  lo <= '1;
               end else begin
                  acc <= div_nxt;
                  cnt <= cnt + 1'b1;
                  if (last) begin
                     lo <= neg_q ? -div_nxt[WIDTH-1:0] : div_nxt[WIDTH-1:0];
                     hi <= neg_r ? -rem_nxt : rem_nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end
endmodule
